// File: rtl/apple2_ps2_pkg.sv
// Shared types and byte constants for the PS/2 keyboard receiver.
package apple2_ps2_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } ps2_state_e;

  // Decoded key event as presented on PS2_Key
  typedef struct packed {
    logic       toggle;
    logic       make;
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

  localparam int unsigned KEY_W = 11;

  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] BYTE_BRK   = 8'hF0;
  localparam logic [7:0] BYTE_PAUSE = 8'hE1;

  // Bytes following E1 that belong to the Pause sequence
  localparam int unsigned PAUSE_SKIP_LEN = 7;

  // Keyboard status/response bytes dropped unless a prefix is pending
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_discard = 1'b1;
      default:                                         is_discard = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus glitch filter for one PS/2 line.
// Ports: clk, rst_n (async, active low), i_line (raw line), o_level (filtered level).
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // r_cnt counts consecutive samples that disagree with the current level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/ps2_key_source.sv
// PS/2 set-2 keyboard receiver producing toggle-flagged key events.
// Ports: CLK_14M (clock), reset_n (async, active low), ps2_clk/ps2_data (raw lines),
//        PS2_Key (event word), frame_err (1-cycle error pulse), busy (frame in progress).
module ps2_key_source
  import apple2_ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 1432
) (
  input  logic             CLK_14M,
  input  logic             reset_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [KEY_W-1:0] PS2_Key,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic            w_clk_filt;
  logic            w_fall;
  logic            w_data;

  logic [1:0]      r_data_sync;
  logic            r_clk_prev;
  ps2_state_e      r_state,     w_state_nxt;
  logic [2:0]      r_bit_cnt,   w_bit_cnt_nxt;
  logic [7:0]      r_shift,     w_shift_nxt;
  logic            r_par_ok,    w_par_ok_nxt;
  logic [TO_W-1:0] r_to_cnt,    w_to_cnt_nxt;
  logic            r_ext,       w_ext_nxt;
  logic            r_brk,       w_brk_nxt;
  logic [2:0]      r_skip,      w_skip_nxt;
  ps2_key_t        r_key,       w_key_nxt;
  logic            r_frame_err, w_frame_err_nxt;
  logic            r_busy,      w_busy_nxt;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk    (CLK_14M),
    .rst_n  (reset_n),
    .i_line (ps2_clk),
    .o_level(w_clk_filt)
  );

  assign w_fall = r_clk_prev & ~w_clk_filt;
  assign w_data = r_data_sync[1];

  // State and datapath registers
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_ok    <= 1'b0;
      r_to_cnt    <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_skip      <= '0;
      r_key       <= '0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_clk_prev  <= w_clk_filt;
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_par_ok    <= w_par_ok_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_ext       <= w_ext_nxt;
      r_brk       <= w_brk_nxt;
      r_skip      <= w_skip_nxt;
      r_key       <= w_key_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Frame sequencing, byte decode and timeout
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_par_ok_nxt    = r_par_ok;
    w_to_cnt_nxt    = (r_state == S_IDLE) ? '0 : r_to_cnt + TO_W'(1);
    w_ext_nxt       = r_ext;
    w_brk_nxt       = r_brk;
    w_skip_nxt      = r_skip;
    w_key_nxt       = r_key;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          if (!w_data) begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = '0;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_fall) begin
          w_shift_nxt   = {w_data, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_fall) begin
          w_par_ok_nxt = ^{r_shift, w_data};
          w_state_nxt  = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          if (!r_par_ok || !w_data) begin
            w_frame_err_nxt = 1'b1;
            w_ext_nxt       = 1'b0;
            w_brk_nxt       = 1'b0;
          end else if (r_skip != 3'd0) begin
            w_skip_nxt = r_skip - 3'd1;
          end else if (r_shift == BYTE_EXT) begin
            w_ext_nxt = 1'b1;
          end else if (r_shift == BYTE_BRK) begin
            w_brk_nxt = 1'b1;
          end else if (r_shift == BYTE_PAUSE) begin
            w_skip_nxt = 3'(PAUSE_SKIP_LEN);
          end else if (is_discard(r_shift) && !r_ext && !r_brk) begin
            w_skip_nxt = r_skip;
          end else begin
            w_key_nxt.toggle = ~r_key.toggle;
            w_key_nxt.make   = ~r_brk;
            w_key_nxt.ext    = r_ext;
            w_key_nxt.code   = r_shift;
            w_ext_nxt        = 1'b0;
            w_brk_nxt        = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // An edge always restarts the timeout and takes priority over it
    if (w_fall) begin
      w_to_cnt_nxt = '0;
    end else if (r_state != S_IDLE && r_to_cnt == TO_W'(TIMEOUT - 1)) begin
      w_state_nxt     = S_IDLE;
      w_frame_err_nxt = 1'b1;
      w_to_cnt_nxt    = '0;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign PS2_Key   = r_key;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ps2_key_source.sv
// Self-checking bench for ps2_key_source: table of frames plus corner-case sequences.
module tb_ps2_key_source;

  localparam int unsigned FILT = 4;
  localparam int unsigned TOUT = 300;
  localparam int          HALF = 20;
  localparam int          GAP  = 80;
  localparam int          NVEC = 25;

  logic        CLK_14M;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] PS2_Key;
  logic        frame_err;
  logic        busy;

  ps2_key_source #(
    .FILTER_LEN(FILT),
    .TIMEOUT   (TOUT)
  ) dut (
    .CLK_14M  (CLK_14M),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .PS2_Key  (PS2_Key),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial CLK_14M = 1'b0;
  always #5 CLK_14M = ~CLK_14M;

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       bad_stop;
    logic       ev;
    logic [9:0] key;
    int         err;
  } vec_t;

  vec_t        tbl [NVEC];
  logic [10:0] exp_q [$];
  logic        exp_tog;
  int          n_checks;
  int          n_errors;
  int          err_seen;
  logic        prev_tog;
  logic        prev_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                           input logic bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic clock_bits(input logic [10:0] vec, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = vec[i];
      repeat (HALF) @(negedge CLK_14M);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge CLK_14M);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic push_event(input logic [9:0] key);
    exp_tog = ~exp_tog;
    exp_q.push_back({exp_tog, key});
  endtask

  // Sends one frame, then checks event drain, error count and busy
  task automatic run_frame(input string name, input logic [7:0] b, input logic bad_par,
                           input logic bad_stop, input logic ev, input logic [9:0] key,
                           input int exp_err);
    int e0;
    e0 = err_seen;
    if (ev) push_event(key);
    clock_bits(mk_frame(b, bad_par, bad_stop), 11);
    repeat (GAP) @(negedge CLK_14M);
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({name, "_err"}, 32'(err_seen - e0), 32'(exp_err));
    check({name, "_busy"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  // Event scoreboard and frame_err pulse monitor
  always @(negedge CLK_14M) begin
    if (!reset_n) begin
      prev_tog = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (PS2_Key[10] !== prev_tog) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event: got 0x%0h expected none at %0t", PS2_Key, $time);
        end else begin
          check("event_key", 32'(PS2_Key), 32'(exp_q.pop_front()));
        end
        prev_tog = PS2_Key[10];
      end
      if (frame_err) begin
        err_seen++;
        check("err_pulse_width", 32'(prev_err), 32'd0);
      end
      prev_err = frame_err;
    end
  end

  initial begin
    int e0;
    n_checks = 0;
    n_errors = 0;
    err_seen = 0;
    exp_tog  = 1'b0;
    prev_tog = 1'b0;
    prev_err = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    reset_n  = 1'b0;

    tbl[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h21C, 0};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[2]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 0};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[4]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[5]  = '{8'h75, 1'b0, 1'b0, 1'b1, 10'h175, 0};
    tbl[6]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 10'h000, 1};
    tbl[7]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h21C, 0};
    tbl[8]  = '{8'hE1, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[9]  = '{8'h14, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[10] = '{8'h77, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[11] = '{8'hE1, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[12] = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[13] = '{8'h14, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[14] = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[15] = '{8'h77, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[16] = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h21C, 0};
    tbl[17] = '{8'hAA, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[18] = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[19] = '{8'hAA, 1'b0, 1'b0, 1'b1, 10'h3AA, 0};
    tbl[20] = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[21] = '{8'h1C, 1'b0, 1'b1, 1'b0, 10'h000, 1};
    tbl[22] = '{8'h77, 1'b0, 1'b0, 1'b1, 10'h277, 0};
    tbl[23] = '{8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[24] = '{8'hFF, 1'b0, 1'b0, 1'b0, 10'h000, 0};

    repeat (5) @(negedge CLK_14M);
    check("reset_key", 32'(PS2_Key), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge CLK_14M);

    for (int i = 0; i < NVEC; i++) begin
      run_frame($sformatf("vec%0d", i), tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop,
                tbl[i].ev, tbl[i].key, tbl[i].err);
    end

    // Timeout mid-frame keeps a pending break prefix
    run_frame("to_brk", 8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 0);
    e0 = err_seen;
    clock_bits(mk_frame(8'h29, 1'b0, 1'b0), 5);
    repeat (10) @(negedge CLK_14M);
    check("to_busy_mid", 32'(busy), 32'd1);
    repeat (TOUT + 50) @(negedge CLK_14M);
    check("to_err", 32'(err_seen - e0), 32'd1);
    check("to_busy_after", 32'(busy), 32'd0);
    run_frame("to_next", 8'h29, 1'b0, 1'b0, 1'b1, 10'h029, 0);

    // Start bit of 1 is rejected
    e0 = err_seen;
    clock_bits(11'h7FF, 1);
    repeat (GAP) @(negedge CLK_14M);
    check("start_err", 32'(err_seen - e0), 32'd1);
    check("start_busy", 32'(busy), 32'd0);
    run_frame("start_next", 8'h1C, 1'b0, 1'b0, 1'b1, 10'h21C, 0);

    // Asynchronous reset during the fifth data bit
    clock_bits(mk_frame(8'h1C, 1'b0, 1'b0), 6);
    repeat (10) @(negedge CLK_14M);
    check("rst_busy_before", 32'(busy), 32'd1);
    check("rst_key_before", 32'(PS2_Key[10]), 32'(exp_tog));
    #2 reset_n = 1'b0;
    #1;
    check("rst_key_async", 32'(PS2_Key), 32'd0);
    check("rst_busy_async", 32'(busy), 32'd0);
    check("rst_err_async", 32'(frame_err), 32'd0);
    exp_tog = 1'b0;
    repeat (3) @(negedge CLK_14M);
    reset_n = 1'b1;
    repeat (10) @(negedge CLK_14M);
    run_frame("rst_next", 8'h1C, 1'b0, 1'b0, 1'b1, 10'h21C, 0);
    check("rst_next_key", 32'(PS2_Key), 32'h61C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
